sub8_apx_pipe: RTL and testbench
================================

SUB8_APX_PIPE -- requirements
Module: sub8_apx_pipe

Interface
REQ-001 Parameter SUM_W, default 24: width of the error-sum accumulator.
REQ-002 Parameter CNT_W, default 16: width of the operation counter.
REQ-003 The block SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand pair present.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a  input  8  unsigned minuend.
REQ-009 b  input  8  unsigned subtrahend.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 d  output  9  approximate difference, two's complement.
REQ-013 err_abs  output  4  |exact - d| for the presented result.
REQ-014 clr_stats  input  1  synchronous clear of the statistics registers.
REQ-015 sum_err  output  SUM_W  saturating sum of err_abs over completed transfers.
REQ-016 n_ops  output  CNT_W  saturating count of completed transfers.
REQ-017 max_err  output  4  maximum err_abs over completed transfers.

Function
REQ-018 Approximate difference: d[0]=a[0]^b[0]; d[1]=a[1]^b[1]; borrow bw=~a[1]&b[1] (bit-0 borrow ignored); d[8:2]={1'b0,a[7:2]}-{1'b0,b[7:2]}-bw, 7-bit wrap.
REQ-019 Exact reference: ex={1'b0,a}-{1'b0,b}, 9-bit two's complement; err_abs=|sext(ex)-sext(d)| computed at 10 bits, truncated to 4 bits (the value never exceeds 4 bits).
REQ-020 Stage 1 SHALL register a, b on an input handshake (in_valid&in_ready); stage 2 SHALL register d, err_abs.
REQ-021 Each stage has a valid bit; a stage loads when empty or when its contents move on in the same cycle.
REQ-022 in_ready SHALL be high unless both stages are full and out_ready is low (combinational from out_ready allowed).
REQ-023 Latency: an operand accepted in cycle N SHALL appear with out_valid high in cycle N+2 when out_ready is held high; throughput 1 per cycle.
REQ-024 While out_valid is high and out_ready is low, d and err_abs SHALL hold stable and no data SHALL be dropped or duplicated.
REQ-025 On an output handshake (out_valid&out_ready): sum_err+=err_abs saturating at all-ones; n_ops+=1 saturating at all-ones; max_err=max(max_err,err_abs).
REQ-026 clr_stats SHALL zero sum_err, n_ops, max_err; if a handshake occurs in the same cycle, the result SHALL be sum_err=err_abs, n_ops=1, max_err=err_abs.
REQ-027 Statistics SHALL be unaffected by in-flight data not yet transferred.

Reset
REQ-028 On rst_n low, asynchronously: both valid bits 0, out_valid=0, d=0, err_abs=0, sum_err=0, n_ops=0, max_err=0; in_ready=1 after release.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operands without producing output.

Verification
REQ-030 a=0x05, b=0x03, out_ready=1 -> two cycles later d=0x002, err_abs=0, n_ops=1.
REQ-031 a=0x02, b=0x01 -> d=0x003, err_abs=2; a=0x00, b=0x01 -> d=0x001, err_abs=2, max_err=2, sum_err=4.
REQ-032 Stream 3 back-to-back ops, out_ready low 4 cycles -> in_ready low after 2 fills, out_valid held, d stable; release -> all 3 results in order, n_ops=3.
REQ-033 Preset sum_err near all-ones via repeated err_abs=2 ops (SUM_W=4 build) -> sum_err saturates at 0xF, no wrap.
REQ-034 clr_stats pulsed in the same cycle as a handshake with err_abs=2 -> sum_err=2, n_ops=1, max_err=2.
REQ-035 rst_n pulsed low with both stages full -> out_valid=0 immediately, all statistics 0, no stale result after release.

Source files
------------

// File: rtl/sub8_apx_pipe.sv
// sub8_apx_pipe: two-stage pipelined approximate 8-bit subtractor.
// The approximation ignores the borrow out of bit 0, and the low two result
// bits are plain XORs. Each result carries its absolute error against the
// exact difference. Running statistics (saturating error sum, saturating
// transfer count and maximum error) are updated only on completed output
// handshakes.
module sub8_apx_pipe #(
  parameter int unsigned SUM_W = 24,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       d,
  output logic [3:0]       err_abs,
  input  logic             clr_stats,
  output logic [SUM_W-1:0] sum_err,
  output logic [CNT_W-1:0] n_ops,
  output logic [3:0]       max_err
);

  // Stage 1: captured operands
  logic       s1_valid;
  logic [7:0] s1_a;
  logic [7:0] s1_b;

  // Stage 2: registered result
  logic       s2_valid;
  logic [8:0] s2_d;
  logic [3:0] s2_err;

  // Handshake / flow control
  logic s2_free;
  logic in_fire;
  logic out_fire;

  // Approximate datapath
  logic       bw;
  logic [6:0] hi_diff;
  logic [8:0] apx_d;
  logic [4:0] ex_lo;
  logic [4:0] diff_lo;
  logic [3:0] apx_err;

  // Statistics next-state helpers
  logic [SUM_W:0]   sum_inc;
  logic [SUM_W-1:0] sum_sat;
  logic [CNT_W-1:0] cnt_sat;
  logic [3:0]       max_next;

  // Flow control: stage 2 can take new data when empty or draining this cycle;
  // stage 1 can take new data when empty or moving into stage 2.
  always_comb begin
    s2_free  = ~s2_valid | out_ready;
    in_ready = ~s1_valid | s2_free;
    in_fire  = in_valid & in_ready;
    out_fire = s2_valid & out_ready;
  end

  // Approximate difference and its absolute error from stage-1 operands.
  // The error is bounded to a few units, so the 10-bit exact-minus-approx
  // difference is evaluated modulo 32 on the low five bits only; the result
  // is identical to the full-width computation for every operand pair.
  always_comb begin
    bw      = ~s1_a[1] & s1_b[1];
    hi_diff = {1'b0, s1_a[7:2]} - {1'b0, s1_b[7:2]} - {6'd0, bw};
    apx_d   = {hi_diff, s1_a[1:0] ^ s1_b[1:0]};
    ex_lo   = s1_a[4:0] - s1_b[4:0];
    diff_lo = ex_lo - apx_d[4:0];
    apx_err = diff_lo[4] ? (~diff_lo[3:0] + 4'd1) : diff_lo[3:0];
  end

  // Saturating statistic updates for a handshake this cycle.
  always_comb begin
    sum_inc  = {1'b0, sum_err} + (SUM_W + 1)'(s2_err);
    sum_sat  = sum_inc[SUM_W] ? '1 : sum_inc[SUM_W-1:0];
    cnt_sat  = (n_ops == '1) ? n_ops : n_ops + CNT_W'(1);
    max_next = (s2_err > max_err) ? s2_err : max_err;
  end

  // Stage 1 register: load operands on an input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_a <= a;
        s1_b <= b;
      end
    end
  end

  // Stage 2 register: capture approximate result when stage 2 is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_d     <= '0;
      s2_err   <= '0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_d   <= apx_d;
        s2_err <= apx_err;
      end
    end
  end

  // Statistics: clear wins over accumulation, but a concurrent handshake
  // is still counted as the first transfer after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_err <= '0;
      n_ops   <= '0;
      max_err <= '0;
    end else if (clr_stats) begin
      sum_err <= out_fire ? SUM_W'(s2_err) : '0;
      n_ops   <= out_fire ? CNT_W'(1) : '0;
      max_err <= out_fire ? s2_err : '0;
    end else if (out_fire) begin
      sum_err <= sum_sat;
      n_ops   <= cnt_sat;
      max_err <= max_next;
    end
  end

  // Output mapping
  always_comb begin
    out_valid = s2_valid;
    d         = s2_d;
    err_abs   = s2_err;
  end

endmodule

// File: tb/tb_sub8_apx_pipe.sv
// Testbench for sub8_apx_pipe: table vectors, hand-written flow-control
// sequences and randomized traffic against a queue-based reference model.
module tb_sub8_apx_pipe;

  localparam longint SUM_MAX  = (64'd1 << 24) - 1;
  localparam longint SUM4_MAX = 15;
  localparam longint CNT_MAX  = (64'd1 << 16) - 1;
  localparam int     NVEC     = 11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready4;
  logic [7:0]  a, b;
  logic        out_valid, out_valid4;
  logic        out_ready;
  logic [8:0]  d, d4;
  logic [3:0]  err_abs, err_abs4;
  logic        clr_stats;
  logic [23:0] sum_err;
  logic [3:0]  sum_err4;
  logic [15:0] n_ops, n_ops4;
  logic [3:0]  max_err, max_err4;

  sub8_apx_pipe #(.SUM_W(24), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .err_abs(err_abs), .clr_stats(clr_stats),
    .sum_err(sum_err), .n_ops(n_ops), .max_err(max_err)
  );

  sub8_apx_pipe #(.SUM_W(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
    .d(d4), .err_abs(err_abs4), .clr_stats(clr_stats),
    .sum_err(sum_err4), .n_ops(n_ops4), .max_err(max_err4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int t;
  } op_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] d;
    logic [3:0] e;
  } vec_t;

  op_t    q[$];
  vec_t   tv[NVEC];
  int     checks = 0;
  int     errors = 0;
  int     edge_cnt = 0;
  longint m_sum, m_sum4, m_n, m_max;
  bit     last_hs_in;

  // Approximate difference straight from the arithmetic definition.
  function automatic int ref_d(int x, int y);
    int bwv;
    int hi;
    bwv = (((x >> 1) & 1) == 0 && ((y >> 1) & 1) == 1) ? 1 : 0;
    hi  = ((x >> 2) - (y >> 2) - bwv) & 127;
    return (hi << 2) | ((x ^ y) & 3);
  endfunction

  function automatic int ref_err(int x, int y);
    int dd;
    int e;
    dd = ref_d(x, y);
    if (dd >= 256) dd = dd - 512;
    e = (x - y) - dd;
    if (e < 0) e = -e;
    return e & 15;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: compare outputs with the model, then advance the model
  // across the next rising edge. Entered and left at a falling edge.
  task automatic step();
    bit ov, ir, hso, hsi;
    int e;
    #1;
    ov = (q.size() > 0) && (q[0].t < edge_cnt);
    ir = !(q.size() == 2 && !out_ready);
    chk("out_valid", out_valid, ov);
    chk("in_ready", in_ready, ir);
    chk("out_valid4", out_valid4, ov);
    chk("in_ready4", in_ready4, ir);
    e = 0;
    if (ov) begin
      e = ref_err(q[0].a, q[0].b);
      chk("d", d, ref_d(q[0].a, q[0].b));
      chk("err_abs", err_abs, e);
      chk("d4", d4, ref_d(q[0].a, q[0].b));
      chk("err_abs4", err_abs4, e);
    end
    chk("sum_err", sum_err, m_sum);
    chk("sum_err4", sum_err4, m_sum4);
    chk("n_ops", n_ops, m_n);
    chk("n_ops4", n_ops4, m_n);
    chk("max_err", max_err, m_max);
    chk("max_err4", max_err4, m_max);
    hso = ov && out_ready;
    hsi = in_valid && ir;
    if (clr_stats) begin
      m_sum  = hso ? e : 0;
      m_sum4 = hso ? e : 0;
      m_n    = hso ? 1 : 0;
      m_max  = hso ? e : 0;
    end else if (hso) begin
      m_sum  = (m_sum + e > SUM_MAX) ? SUM_MAX : m_sum + e;
      m_sum4 = (m_sum4 + e > SUM4_MAX) ? SUM4_MAX : m_sum4 + e;
      m_n    = (m_n + 1 > CNT_MAX) ? CNT_MAX : m_n + 1;
      if (e > m_max) m_max = e;
    end
    if (hso) void'(q.pop_front());
    if (hsi) q.push_back('{int'(a), int'(b), edge_cnt + 1});
    last_hs_in = hsi;
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
  endtask

  task automatic send(logic [7:0] x, logic [7:0] y);
    a = x;
    b = y;
    in_valid = 1'b1;
    last_hs_in = 1'b0;
    for (int i = 0; i < 8 && !last_hs_in; i++) step();
    if (!last_hs_in) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    clr_stats = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d", d, 0);
    chk("rst_err_abs", err_abs, 0);
    chk("rst_sum_err", sum_err, 0);
    chk("rst_sum_err4", sum_err4, 0);
    chk("rst_n_ops", n_ops, 0);
    chk("rst_max_err", max_err, 0);
    q.delete();
    m_sum = 0; m_sum4 = 0; m_n = 0; m_max = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{8'h05, 8'h03, 9'h002, 4'd0};
    tv[1]  = '{8'h02, 8'h01, 9'h003, 4'd2};
    tv[2]  = '{8'h00, 8'h01, 9'h001, 4'd2};
    tv[3]  = '{8'hFF, 8'h00, 9'h0FF, 4'd0};
    tv[4]  = '{8'h00, 8'hFF, 9'h103, 4'd2};
    tv[5]  = '{8'h80, 8'h80, 9'h000, 4'd0};
    tv[6]  = '{8'h01, 8'h02, 9'h1FF, 4'd0};
    tv[7]  = '{8'h03, 8'h01, 9'h002, 4'd0};
    tv[8]  = '{8'h10, 8'h03, 9'h00F, 4'd2};
    tv[9]  = '{8'h01, 8'h03, 9'h1FE, 4'd0};
    tv[10] = '{8'h02, 8'h03, 9'h001, 4'd2};

    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
    a = '0;
    b = '0;
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Table vectors, one at a time, with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      send(tv[i].a, tv[i].b);
      step();
      #1;
      chk("tbl_out_valid", out_valid, 1);
      chk("tbl_d", d, tv[i].d);
      chk("tbl_err", err_abs, tv[i].e);
      step();
      if (i == 0) chk("first_n_ops", n_ops, 1);
      if (i == 2) begin
        chk("seq_sum_err", sum_err, 4);
        chk("seq_max_err", max_err, 2);
      end
    end

    // Backpressure: three back-to-back ops, consumer stalled.
    out_ready = 1'b0;
    a = 8'h05; b = 8'h03; in_valid = 1'b1;
    step();
    a = 8'h02; b = 8'h01;
    step();
    a = 8'h00; b = 8'h01;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_d_stable", d, 9'h002);
      step();
    end
    out_ready = 1'b1;
    last_hs_in = 1'b0;
    for (int i = 0; i < 4 && !last_hs_in; i++) step();
    if (!last_hs_in) chk("bp_accept_timeout", 0, 1);
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_n_ops", n_ops, NVEC + 3);

    // Clear coinciding with a handshake carrying err_abs=2.
    send(8'h02, 8'h01);
    step();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("clr_sum_err", sum_err, 2);
    chk("clr_n_ops", n_ops, 1);
    chk("clr_max_err", max_err, 2);

    // Saturation of the narrow accumulator.
    for (int i = 0; i < 10; i++) send(8'h02, 8'h01);
    repeat (4) step();
    chk("sat_sum_err4", sum_err4, 15);
    chk("sat_sum_err", sum_err, 22);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(8'h05, 8'h03);
    send(8'h02, 8'h01);
    step();
    do_reset();
    out_ready = 1'b1;
    repeat (5) begin
      #1;
      chk("post_rst_no_output", out_valid, 0);
      step();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_stats = ($urandom_range(0, 40) == 0);
      step();
    end
    in_valid  = 1'b0;
    clr_stats = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("drain_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
